// File: rtl/adder_arbiter.sv
// Two-requester round-robin front end sharing one registered adder.
// One operation in flight: IDLE arbitrates, EXEC adds, DONE holds until rdy.
module adder_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic [7:0]       xin0,
    input  logic [7:0]       xin1,
    input  logic             rdy,
    output logic [1:0]       gnt,
    output logic [WIDTH-1:0] s,
    output logic [7:0]       xout,
    output logic             ovf,
    output logic             owner,
    output logic             done
);

    localparam logic [7:0] ASCII_G = 8'h67;
    localparam logic [7:0] ASCII_K = 8'h6B;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             cin_q;
    logic             last_q;
    logic [1:0]       gnt_q;
    logic             done_q;
    logic [WIDTH-1:0] s_q;
    logic [7:0]       xout_q;
    logic             ovf_q;
    logic             owner_q;

    logic             winner_d;
    logic [WIDTH-1:0] opa_d;
    logic [WIDTH-1:0] opb_d;
    logic             cin_d;
    logic [WIDTH-1:0] sum_d;
    logic             carry_d;
    logic             ovf_d;

    // On a tie the requester that was not served last wins; a lone requester always wins.
    always_comb begin
        winner_d = req[0] ? (req[1] & ~last_q) : 1'b1;
        opa_d    = winner_d ? a1 : a0;
        opb_d    = winner_d ? b1 : b0;
        cin_d    = ((winner_d ? xin1 : xin0) == ASCII_G);
    end

    // The single shared adder works only on the latched operands.
    always_comb begin
        {carry_d, sum_d} = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, cin_q};
        ovf_d            = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_d[WIDTH-1] != a_q[WIDTH-1]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            cin_q   <= 1'b0;
            last_q  <= 1'b1;
            gnt_q   <= 2'b00;
            done_q  <= 1'b0;
            s_q     <= '0;
            xout_q  <= ASCII_K;
            ovf_q   <= 1'b0;
            owner_q <= 1'b0;
        end else begin
            gnt_q <= 2'b00;
            case (state_q)
                IDLE: begin
                    if (req != 2'b00) begin
                        a_q     <= opa_d;
                        b_q     <= opb_d;
                        cin_q   <= cin_d;
                        owner_q <= winner_d;
                        gnt_q   <= winner_d ? 2'b10 : 2'b01;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    s_q     <= sum_d;
                    xout_q  <= carry_d ? ASCII_G : ASCII_K;
                    ovf_q   <= ovf_d;
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end
                DONE: begin
                    // History only advances once the consumer has taken the result.
                    if (rdy) begin
                        done_q  <= 1'b0;
                        last_q  <= owner_q;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt   = gnt_q;
    assign done  = done_q;
    assign s     = s_q;
    assign xout  = xout_q;
    assign ovf   = ovf_q;
    assign owner = owner_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Scoreboard bench for adder_arbiter: directed requests push expected grants and
// results; a negedge monitor pops and compares whenever gnt pulses or a result is taken.
module tb_adder_arbiter;

    localparam logic [7:0] G = 8'h67;
    localparam logic [7:0] K = 8'h6B;

    typedef struct {
        logic [31:0] s;
        logic [7:0]  xout;
        logic        ovf;
        logic        owner;
    } result_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req;
    logic [31:0] a0, b0, a1, b1;
    logic [7:0]  xin0, xin1;
    logic        rdy;
    logic [1:0]  gnt;
    logic [31:0] s;
    logic [7:0]  xout;
    logic        ovf;
    logic        owner;
    logic        done;

    result_t     resQ[$];
    logic [1:0]  gntQ[$];
    int          errors = 0;
    int          checks = 0;
    int          n;

    adder_arbiter #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .xin0(xin0), .xin1(xin1), .rdy(rdy),
        .gnt(gnt), .s(s), .xout(xout), .ovf(ovf), .owner(owner), .done(done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Sets operands for requester idx, raises its request and queues the expectations.
    task automatic raiseReq(input int idx, input logic [31:0] a, input logic [31:0] b, input logic [7:0] xin,
                            input logic [31:0] es, input logic [7:0] ex, input logic eo, input logic pushRes);
        result_t r;
        if (idx == 0) begin a0 = a; b0 = b; xin0 = xin; end
        else          begin a1 = a; b1 = b; xin1 = xin; end
        req[idx] = 1'b1;
        gntQ.push_back(idx == 0 ? 2'b01 : 2'b10);
        if (pushRes) begin
            r.s = es; r.xout = ex; r.ovf = eo; r.owner = idx[0];
            resQ.push_back(r);
        end
    endtask

    task automatic waitGnt(input int idx, output int cyc);
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (!gnt[idx] && cyc < 40);
        if (!gnt[idx]) checkOutput("gntTimeout", 32'd0, 32'd1);
    endtask

    // Operands are scrambled right after the grant so a late change would corrupt the result.
    task automatic applyStimulus(input int idx, input logic [31:0] a, input logic [31:0] b, input logic [7:0] xin,
                                 input logic [31:0] es, input logic [7:0] ex, input logic eo);
        int c;
        raiseReq(idx, a, b, xin, es, ex, eo, 1'b1);
        waitGnt(idx, c);
        req[idx] = 1'b0;
        if (idx == 0) begin a0 = $urandom; b0 = $urandom; xin0 = G; end
        else          begin a1 = $urandom; b1 = $urandom; xin1 = G; end
    endtask

    task automatic drain();
        int c = 0;
        while ((resQ.size() != 0 || done) && c < 40) begin
            @(posedge clk); #1;
            c++;
        end
        checkOutput("drainTimeout", resQ.size(), 32'd0);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_gnt"},   {30'd0, gnt}, 32'd0);
        checkOutput({tag, "_done"},  {31'd0, done}, 32'd0);
        checkOutput({tag, "_s"},     s, 32'd0);
        checkOutput({tag, "_xout"},  {24'd0, xout}, {24'd0, K});
        checkOutput({tag, "_ovf"},   {31'd0, ovf}, 32'd0);
        checkOutput({tag, "_owner"}, {31'd0, owner}, 32'd0);
    endtask

    always @(negedge clk) begin
        if (gnt != 2'b00) begin
            if (gntQ.size() == 0) checkOutput("unexpectedGnt", {30'd0, gnt}, 32'd0);
            else                  checkOutput("gnt", {30'd0, gnt}, {30'd0, gntQ.pop_front()});
        end
        if (done && rdy) begin
            if (resQ.size() == 0) checkOutput("unexpectedDone", {31'd0, done}, 32'd0);
            else begin
                result_t r;
                r = resQ.pop_front();
                checkOutput("sum",   s, r.s);
                checkOutput("xout",  {24'd0, xout}, {24'd0, r.xout});
                checkOutput("ovf",   {31'd0, ovf}, {31'd0, r.ovf});
                checkOutput("owner", {31'd0, owner}, {31'd0, r.owner});
            end
        end
    end

    initial begin
        rst_n = 1'b0; req = 2'b00; rdy = 1'b1;
        a0 = 32'd0; b0 = 32'd0; a1 = 32'd0; b1 = 32'd0; xin0 = K; xin1 = K;
        repeat (2) @(posedge clk);
        #1;
        checkResetState("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        applyStimulus(0, 32'd36865, 32'd33023, K, 32'd69888, K, 1'b0);
        drain();
        applyStimulus(1, 32'd36865, -32'sd36864, K, 32'd1, G, 1'b0);
        drain();
        applyStimulus(1, 32'd1, -32'sd2, G, 32'd0, G, 1'b0);
        drain();
        applyStimulus(0, 32'h7FFF_FFFF, 32'd1, K, 32'h8000_0000, K, 1'b1);
        drain();
        applyStimulus(0, 32'h8000_0000, 32'h8000_0000, G, 32'd1, G, 1'b1);
        drain();

        // Both requesters held from reset: grants alternate, starting with requester 0.
        rst_n = 1'b0;
        a0 = 32'd1; b0 = 32'd2; xin0 = G; a1 = 32'd10; b1 = 32'd20; xin1 = K;
        req = 2'b11;
        gntQ.push_back(2'b01); gntQ.push_back(2'b10); gntQ.push_back(2'b01); gntQ.push_back(2'b10);
        for (int i = 0; i < 4; i++) begin
            result_t r;
            r.s = (i % 2 == 0) ? 32'd4 : 32'd30; r.xout = K; r.ovf = 1'b0; r.owner = (i % 2 == 1);
            resQ.push_back(r);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        waitGnt(0, n);
        checkOutput("rrFirstLatency", n, 32'd1);
        waitGnt(1, n);
        checkOutput("rrSpacing1", n, 32'd3);
        waitGnt(0, n);
        checkOutput("rrSpacing2", n, 32'd3);
        waitGnt(1, n);
        checkOutput("rrSpacing3", n, 32'd3);
        req = 2'b00;
        drain();

        // Result held while rdy is low; a new request waits for IDLE.
        rdy = 1'b0;
        applyStimulus(0, 32'd5, 32'd6, K, 32'd11, K, 1'b0);
        @(posedge clk); #1;
        raiseReq(1, 32'd100, 32'hFFFF_FFFF, G, 32'd100, G, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checkOutput("holdDone", {31'd0, done}, 32'd1);
            checkOutput("holdSum", s, 32'd11);
            checkOutput("holdNoGnt", {30'd0, gnt}, 32'd0);
        end
        rdy = 1'b1;
        waitGnt(1, n);
        checkOutput("postRdyGntLatency", n, 32'd2);
        req = 2'b00;
        drain();

        // Reset during EXEC abandons the operation.
        raiseReq(0, 32'd7, 32'd8, K, 32'd0, K, 1'b0, 1'b0);
        waitGnt(0, n);
        req = 2'b00;
        rst_n = 1'b0;
        @(posedge clk); #1;
        checkResetState("abort");
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            checkOutput("abortNoDone", {31'd0, done}, 32'd0);
        end

        checkOutput("gntQueueEmpty", gntQ.size(), 32'd0);
        checkOutput("resQueueEmpty", resQ.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
